// File: rtl/video_timing_gen.sv
// Raster timing generator for the video path: pixel enable, h/v counters,
// blank/sync flags and PAL/NTSC/scandouble mode switching at frame boundaries.
module video_timing_gen #(
  parameter int HW            = 10,
  parameter int VW            = 10,
  parameter int H_TOTAL       = 638,
  parameter int H_BLANK_START = 529,
  parameter int H_SYNC_START  = 544,
  parameter int H_SYNC_END    = 590,
  parameter int PAL_LINES     = 312,
  parameter int NTSC_LINES    = 262,
  parameter int PAL_VB_START  = 300,
  parameter int PAL_VS_START  = 304,
  parameter int PAL_VS_END    = 308,
  parameter int NTSC_VB_START = 240,
  parameter int NTSC_VS_START = 245,
  parameter int NTSC_VS_END   = 248
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pal,
  input  logic          scandouble,
  output logic          ce_pix,
  output logic [HW-1:0] hc,
  output logic [VW-1:0] vc,
  output logic          HBlank,
  output logic          HSync,
  output logic          VBlank,
  output logic          VSync,
  output logic          field,
  output logic          line_start,
  output logic          frame_start,
  output logic          pal_active,
  output logic          sd_active
);

  if (!(H_BLANK_START < H_SYNC_START && H_SYNC_START < H_SYNC_END &&
        H_SYNC_END < H_TOTAL && H_TOTAL <= (1 << HW) &&
        PAL_VB_START < PAL_VS_START && PAL_VS_START < PAL_VS_END &&
        PAL_VS_END < PAL_LINES && NTSC_VB_START < NTSC_VS_START &&
        NTSC_VS_START < NTSC_VS_END && NTSC_VS_END < NTSC_LINES &&
        2 * PAL_LINES <= (1 << VW) && 2 * NTSC_LINES <= (1 << VW))) begin : gBadParams
    $error("video_timing_gen: inconsistent timing parameters");
  end

  localparam logic [HW-1:0] HOne        = HW'(1);
  localparam logic [VW-1:0] VOne        = VW'(1);
  localparam logic [HW-1:0] HLast       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HBlankStart = HW'(H_BLANK_START);
  localparam logic [HW-1:0] HSyncStart  = HW'(H_SYNC_START);
  localparam logic [HW-1:0] HSyncEnd    = HW'(H_SYNC_END);
  localparam logic [VW-1:0] PalLines    = VW'(PAL_LINES);
  localparam logic [VW-1:0] NtscLines   = VW'(NTSC_LINES);
  localparam logic [VW-1:0] PalVbStart  = VW'(PAL_VB_START);
  localparam logic [VW-1:0] PalVsStart  = VW'(PAL_VS_START);
  localparam logic [VW-1:0] PalVsEnd    = VW'(PAL_VS_END);
  localparam logic [VW-1:0] NtscVbStart = VW'(NTSC_VB_START);
  localparam logic [VW-1:0] NtscVsStart = VW'(NTSC_VS_START);
  localparam logic [VW-1:0] NtscVsEnd   = VW'(NTSC_VS_END);

  logic          ce_q;
  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  logic          hBlank_q, hSync_q, vBlank_q, vSync_q;
  logic          field_q, lineStart_q, frameStart_q;
  logic          palActive_q, sdActive_q;
  logic          lineWrap, frameWrap;
  logic [VW-1:0] vTotal, vbStart, vsStart, vsEnd;

  // Vertical geometry is doubled in line count when scandoubling.
  always_comb begin
    vTotal  = (palActive_q ? PalLines   : NtscLines)   << sdActive_q;
    vbStart = (palActive_q ? PalVbStart : NtscVbStart) << sdActive_q;
    vsStart = (palActive_q ? PalVsStart : NtscVsStart) << sdActive_q;
    vsEnd   = (palActive_q ? PalVsEnd   : NtscVsEnd)   << sdActive_q;
  end

  always_comb begin
    lineWrap  = (hc_q == HLast);
    frameWrap = lineWrap && (vc_q == vTotal - VOne);
    hc_d      = lineWrap ? '0 : hc_q + HOne;
    vc_d      = vc_q;
    if (lineWrap) begin
      vc_d = frameWrap ? '0 : vc_q + VOne;
    end
  end

  // Everything but ce_pix advances only on ce cycles; mode inputs are
  // captured solely on the frame wrap so frames are never truncated.
  always_ff @(posedge clk) begin
    if (reset) begin
      ce_q         <= 1'b0;
      hc_q         <= '0;
      vc_q         <= '0;
      hBlank_q     <= 1'b0;
      hSync_q      <= 1'b0;
      vBlank_q     <= 1'b0;
      vSync_q      <= 1'b0;
      field_q      <= 1'b0;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
      palActive_q  <= pal;
      sdActive_q   <= scandouble;
    end else begin
      ce_q         <= sdActive_q ? 1'b1 : ~ce_q;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
      if (ce_q) begin
        hc_q         <= hc_d;
        vc_q         <= vc_d;
        lineStart_q  <= lineWrap;
        frameStart_q <= frameWrap;

        if (hc_q == HBlankStart) begin
          hBlank_q <= 1'b1;
        end else if (hc_q == '0) begin
          hBlank_q <= 1'b0;
        end

        if (hc_q == HSyncStart) begin
          hSync_q <= 1'b1;
        end else if (hc_q == HSyncEnd) begin
          hSync_q <= 1'b0;
        end

        // Vertical flags switch mid-line, aligned with the leading edge of HSync.
        if (hc_q == HSyncStart) begin
          if (vc_q == vbStart) begin
            vBlank_q <= 1'b1;
          end else if (vc_q == '0) begin
            vBlank_q <= 1'b0;
          end
          if (vc_q == vsStart) begin
            vSync_q <= 1'b1;
          end else if (vc_q == vsEnd) begin
            vSync_q <= 1'b0;
          end
        end

        if (frameWrap) begin
          field_q     <= ~field_q;
          palActive_q <= pal;
          sdActive_q  <= scandouble;
        end
      end
    end
  end

  assign ce_pix      = ce_q;
  assign hc          = hc_q;
  assign vc          = vc_q;
  assign HBlank      = hBlank_q;
  assign HSync       = hSync_q;
  assign VBlank      = vBlank_q;
  assign VSync       = vSync_q;
  assign field       = field_q;
  assign line_start  = lineStart_q;
  assign frame_start = frameStart_q;
  assign pal_active  = palActive_q;
  assign sd_active   = sdActive_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen using a shrunken raster so that
// several complete frames fit in a short run.
module tb_video_timing_gen;

  localparam int HT  = 40;
  localparam int HBS = 30;
  localparam int HSS = 33;
  localparam int HSE = 37;
  localparam int PL  = 20;
  localparam int PVB = 14;
  localparam int PVS = 16;
  localparam int PVE = 18;
  localparam int NL  = 16;
  localparam int NVB = 10;
  localparam int NVS = 12;
  localparam int NVE = 14;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pal = 1'b1;
  logic       scandouble = 1'b0;
  logic       ce_pix;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       HBlank, HSync, VBlank, VSync, field;
  logic       line_start, frame_start, pal_active, sd_active;

  video_timing_gen #(
    .HW(10), .VW(10), .H_TOTAL(HT), .H_BLANK_START(HBS),
    .H_SYNC_START(HSS), .H_SYNC_END(HSE),
    .PAL_LINES(PL), .NTSC_LINES(NL),
    .PAL_VB_START(PVB), .PAL_VS_START(PVS), .PAL_VS_END(PVE),
    .NTSC_VB_START(NVB), .NTSC_VS_START(NVS), .NTSC_VS_END(NVE)
  ) dut (
    .clk(clk), .reset(reset), .pal(pal), .scandouble(scandouble),
    .ce_pix(ce_pix), .hc(hc), .vc(vc),
    .HBlank(HBlank), .HSync(HSync), .VBlank(VBlank), .VSync(VSync),
    .field(field), .line_start(line_start), .frame_start(frame_start),
    .pal_active(pal_active), .sd_active(sd_active)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] expQ[$];
  int          fsTimes[$];
  int          cycleCount;
  int          vsClks;

  // Reference model state: counters and modes stepped per clock edge.
  logic mCe, mPal, mSd, mField, mLs, mFs;
  int   mHc, mVc;
  bit   hStarted, vStarted;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic int vTotalModel();
    return (mPal ? PL : NL) * (mSd ? 2 : 1);
  endfunction

  task automatic modelStep(input logic r, input logic p, input logic s);
    logic wasCe;
    if (r) begin
      mCe = 1'b0; mHc = 0; mVc = 0; mPal = p; mSd = s;
      mField = 1'b0; mLs = 1'b0; mFs = 1'b0;
      hStarted = 1'b0; vStarted = 1'b0;
    end else begin
      wasCe = mCe;
      mCe   = mSd ? 1'b1 : !mCe;
      mLs   = 1'b0;
      mFs   = 1'b0;
      if (wasCe) begin
        hStarted = 1'b1;
        if (mHc == HT - 1) begin
          mHc = 0;
          mLs = 1'b1;
          if (mVc == vTotalModel() - 1) begin
            mVc = 0; mFs = 1'b1; mField = !mField;
            mPal = p; mSd = s; vStarted = 1'b1;
          end else begin
            mVc++;
          end
        end else begin
          mHc++;
        end
      end
    end
  endtask

  // Flags are derived from the displayed position rather than stepped:
  // each flag is visible from one ce after its trigger position.
  function automatic logic [31:0] expectedWord();
    int   m, vbT, vsT, veT;
    logic hb, hs, vb, vs;
    m   = mSd ? 2 : 1;
    vbT = (mPal ? PVB : NVB) * m;
    vsT = (mPal ? PVS : NVS) * m;
    veT = (mPal ? PVE : NVE) * m;
    hb  = (mHc > HBS) || (mHc == 0 && hStarted);
    hs  = (mHc > HSS) && (mHc <= HSE);
    vb  = (mVc > vbT) || (mVc == vbT && mHc > HSS) ||
          (mVc == 0 && mHc <= HSS && vStarted);
    vs  = (mVc == vsT && mHc > HSS) || (mVc > vsT && mVc < veT) ||
          (mVc == veT && mHc <= HSS);
    return {2'b00, mCe, 10'(mHc), 10'(mVc), hb, hs, vb, vs,
            mField, mLs, mFs, mPal, mSd};
  endfunction

  function automatic logic [31:0] observedWord();
    return {2'b00, ce_pix, hc, vc, HBlank, HSync, VBlank, VSync,
            field, line_start, frame_start, pal_active, sd_active};
  endfunction

  task automatic applyStimulus(input logic r, input logic p, input logic s,
                               input string tag);
    logic [31:0] exp;
    reset = r; pal = p; scandouble = s;
    modelStep(r, p, s);
    expQ.push_back(expectedWord());
    @(posedge clk);
    #1;
    exp = expQ.pop_front();
    checkOutput(tag, observedWord(), exp);
    cycleCount++;
    if (frame_start === 1'b1) fsTimes.push_back(cycleCount);
    if (VSync === 1'b1) vsClks++;
  endtask

  task automatic startPhase(input logic p, input logic s, input string tag);
    applyStimulus(1'b1, p, s, tag);
    applyStimulus(1'b1, p, s, tag);
    cycleCount = 0;
    vsClks = 0;
    fsTimes.delete();
  endtask

  task automatic checkFrames(input string tag, input int count,
                             input int period);
    checkOutput({tag, "_fs_count"}, 32'(fsTimes.size()), 32'(count));
    for (int i = 1; i < fsTimes.size(); i++) begin
      checkOutput({tag, "_period"}, 32'(fsTimes[i] - fsTimes[i-1]), 32'(period));
    end
  endtask

  initial begin
    bit reached;

    // PAL single-scan: three frames, half-rate pixel enable.
    startPhase(1'b1, 1'b0, "pal_rst");
    for (int i = 0; i < 5000; i++) applyStimulus(1'b0, 1'b1, 1'b0, "pal_sd0");
    checkFrames("pal", 3, HT * PL * 2);
    checkOutput("pal_vsync_clks", 32'(vsClks), 32'(3 * (PVE - PVS) * HT * 2));
    checkOutput("field_after_3", 32'(field), 32'd1);

    // NTSC scandoubled: full-rate enable, doubled line count.
    startPhase(1'b0, 1'b1, "ntsc_rst");
    for (int i = 0; i < 2700; i++) applyStimulus(1'b0, 1'b0, 1'b1, "ntsc_sd1");
    checkFrames("ntsc", 2, HT * NL * 2);
    checkOutput("ntsc_vsync_clks", 32'(vsClks), 32'(2 * (NVE - NVS) * 2 * HT));

    // Reset mid-line, mid-frame.
    reached = 1'b0;
    for (int i = 0; i < 3000 && !reached; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, "ntsc_run");
      reached = (mHc == 20 && mVc == 12);
    end
    checkOutput("reach_midline", 32'(reached), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, "mid_rst");
    checkOutput("mid_rst_hc", 32'(hc), 32'd0);
    checkOutput("mid_rst_vc", 32'(vc), 32'd0);
    checkOutput("mid_rst_ce", 32'(ce_pix), 32'd0);
    checkOutput("mid_rst_flags", 32'({HBlank, HSync, VBlank, VSync, field}), 32'd0);
    for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b1, 1'b0, "post_rst");

    // Mode switch NTSC -> PAL requested mid-frame.
    startPhase(1'b0, 1'b0, "sw_rst");
    while (mVc != 5 && cycleCount < 2000) applyStimulus(1'b0, 1'b0, 1'b0, "sw_ntsc");
    checkOutput("sw_reach_vc5", 32'(mVc), 32'd5);
    checkOutput("sw_still_ntsc", 32'(pal_active), 32'd0);
    while (cycleCount < 3000) applyStimulus(1'b0, 1'b1, 1'b0, "sw_pal");
    checkFrames("sw", 2, HT * PL * 2);
    checkOutput("sw_first_frame", 32'(fsTimes.size() > 0 ? fsTimes[0] : 0),
                32'(HT * NL * 2));
    checkOutput("sw_pal_active", 32'(pal_active), 32'd1);
    checkOutput("sw_field", 32'(field), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised raster timing generator for the CD-i video path, replacing hard-coded horizontal/vertical counters in the top level.
- Produces pixel clock enable, h/v counters, blank/sync flags, field bit and line/frame start strobes for PAL/NTSC, single-scan or scandoubled output.
- All timing points are parameters.
- Mode inputs are latched only at frame boundaries, so a mid-frame mode change never produces a truncated or over-long frame.
- Sits between the clock/reset domain and the video output stage (MCD212 pixel path, scandoubler).

Parameters:
HW, 10, width of hc output
VW, 10, width of vc output
H_TOTAL, 638, pixels per line
H_BLANK_START, 529, hc at which HBlank asserts
H_SYNC_START, 544, hc at which HSync asserts; vertical flags evaluated here
H_SYNC_END, 590, hc at which HSync deasserts
PAL_LINES, 312, single-scan lines per PAL frame
NTSC_LINES, 262, single-scan lines per NTSC frame
PAL_VB_START / PAL_VS_START / PAL_VS_END, 300 / 304 / 308, PAL vertical events (single-scan lines)
NTSC_VB_START / NTSC_VS_START / NTSC_VS_END, 240 / 245 / 248, NTSC vertical events (single-scan lines)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pal  in  1  requested mode: 1 = PAL, 0 = NTSC
scandouble  in  1  requested mode: 1 = doubled line rate
ce_pix  out  1  pixel clock enable
hc  out  HW  horizontal pixel counter
vc  out  VW  vertical line counter
HBlank  out  1  horizontal blank
HSync  out  1  horizontal sync, active-high
VBlank  out  1  vertical blank
VSync  out  1  vertical sync, active-high
field  out  1  toggles every frame
line_start  out  1  one-clk strobe, first pixel of each line
frame_start  out  1  one-clk strobe, first pixel of each frame
pal_active  out  1  latched PAL mode in effect
sd_active  out  1  latched scandouble mode in effect

Behaviour:
Reset (sync, active-high):
- Reset values: ce_pix=0, hc=0, vc=0, all flags 0, field=0, strobes 0.
- pal_active <= pal, sd_active <= scandouble.

ce_pix:
- sd_active=1: ce_pix=1 every clk.
- sd_active=0: ce_pix toggles every clk, giving a 1/2 rate.
- A "ce cycle" is a clk edge where the registered ce_pix=1.
- All counters, flags and strobes change only on ce cycles. Strobes are forced to 0 on non-ce clks.

Counters:
- hc increments per ce cycle; wraps H_TOTAL-1 -> 0.
- On the hc wrap, vc increments. V_TOTAL = (pal_active ? PAL_LINES : NTSC_LINES) << sd_active. vc wraps V_TOTAL-1 -> 0.
- On a frame wrap (hc and vc both wrapping), in the same ce cycle:
  - pal_active <= pal, sd_active <= scandouble.
  - field toggles.
- New mode governs the next frame from hc=0, vc=0. The ce_pix rate changes from the next clk.

Horizontal flags:
- Evaluated on ce cycles from the current hc value; flags update one ce later than the hc value that triggers them.
- HBlank: set when hc==H_BLANK_START, cleared when hc==0.
- HSync: set when hc==H_SYNC_START, cleared when hc==H_SYNC_END.

Vertical flags:
- Evaluated only on ce cycles with hc==H_SYNC_START.
- Thresholds are the per-mode parameter values << sd_active.
- VBlank: set at vc==VB_START, cleared at vc==0.
- VSync: set at vc==VS_START, cleared at vc==VS_END.

Strobes:
- line_start=1 on the clk after a ce cycle whose next hc is 0.
- frame_start additionally requires next vc=0. It coincides with a line_start.

Boundary conditions:
- Mode input changes mid-frame have no effect until the frame wrap.
- Reset mid-line restarts the count at hc=0, vc=0 immediately.
- Parameter constraints: H_BLANK_START < H_SYNC_START < H_SYNC_END < H_TOTAL, VB_START < VS_START < VS_END < LINES. Checked by elaboration-time assertion.

Test Plan:
- PAL, sd=0, from reset: ce_pix alternates 0/1; frame_start period = 638*312*2 = 398112 clk; VSync high for 4 lines (vc 304..307 at HSync edge).
- NTSC, sd=1: ce_pix constant 1; V_TOTAL=524; frame period 638*524 = 334312 clk; VBlank asserts at vc=480, clears at vc=0; VSync asserts at 490, clears at 496.
- Mode switch: toggle pal 0->1 at vc=100 -> current NTSC frame completes at 262 lines; pal_active and field flip on the wrap; next frame 312 lines.
- Horizontal: within one line, HBlank rises on the clk after the ce cycle with hc=529; HSync is high for 46 ce cycles (544..589); line_start is high once per 638 ce cycles.
- Reset at hc=300, vc=150 -> next clk: hc=0, vc=0, all flags and field 0, ce_pix 0; timing resumes cleanly.
- field toggles on every frame_start; after 3 frames, field=1.
